instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage of the j2 core, directly upstream of the instruction RAM and
//  downstream of the core's branch/PC-redirect logic. Owns the program counter,
//  drives the RAM read address, absorbs the RAM's 1-cycle registered-read
//  latency and presents instructions to decode over a valid/ready handshake.
//  Buffers fetched words so decode stalls never lose instructions.
// PARAMETERS
//  ADDR_WIDTH  13  instruction address width (word-addressed)
//  DATA_WIDTH  16  instruction word width
//  RESET_ADDR  0   PC value loaded on reset
//  BUF_DEPTH   2   instruction buffer entries; 2 gives full throughput
// PORTS
//  clock             in   1           single clock, all state on posedge
//  reset_n           in   1           synchronous, active-low reset
//  fetch_enable      in   1           1 = run, 0 = halt issuing new fetches
//  redirect_valid    in   1           branch/call/return: load PC, flush
//  redirect_address  in   ADDR_WIDTH  new PC when redirect_valid
//  fetch_address     out  ADDR_WIDTH  RAM read address (RAM samples on posedge)
//  fetch_data        in   DATA_WIDTH  RAM word, valid 1 cycle after address
//  instr_valid       out  1           instr/instr_pc valid for decode
//  instr_ready       in   1           decode accepts this cycle
//  instr             out  DATA_WIDTH  instruction word
//  instr_pc          out  ADDR_WIDTH  address of instr
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): pc=RESET_ADDR, state=HALTED, buffer empty,
//    in-flight flag clear, instr_valid=0, instr=0, instr_pc=0. Mid-operation
//    reset discards in-flight fetch and buffer contents.
//  - FSM: HALTED -> RUNNING when fetch_enable=1; RUNNING -> HALTED when
//    fetch_enable=0. HALTED issues no fetches but buffered words still drain.
//  - fetch_address = redirect_valid ? redirect_address : pc (combinational).
//  - Issue when RUNNING and (count + inflight < BUF_DEPTH, or == BUF_DEPTH with
//    a pop this cycle). On issue: inflight<=1, inflight_pc<=fetch_address,
//    pc<=fetch_address+1, wrapping 2^ADDR_WIDTH-1 -> 0.
//  - Cycle after issue: fetch_data pushed with inflight_pc into buffer tail.
//  - instr/instr_pc/instr_valid come from buffer head (registered, no bypass).
//    Pop on instr_valid & instr_ready. Latency address-issue -> instr_valid = 2.
//  - Redirect: buffer flushed, in-flight word discarded (not pushed), target
//    issued same cycle if RUNNING, else pc<=redirect_address. Redirect
//    has priority over push and predecode; a handshake in the same cycle still
//    completes (decode consumed that word).
//  - instr/instr_pc hold stable while instr_valid=1 and instr_ready=0.
//  - Full buffer with pending in-flight never occurs (credit rule); push on
//    full is an assertion failure.
// CONFIGURATION
//  IFETCH_JUMP_PREDECODE_EN defined: the word returned for an in-flight fetch
//    with bits[15:13]==3'b000 (unconditional jump) sets pc<=word[12:0]; the
//    sequential fetch issued that same cycle is squashed (not pushed). Jump word
//    itself is still delivered to decode. redirect_valid overrides.
//  Not defined: no predecode; jumps resolve only via redirect_valid.
// STRUCTURE
//  - common.h: ADDR_WIDTH/DATA_WIDTH defaults, RESET_ADDR, opcode field
//    constants (OP_JUMP=3'b000, OP_CJUMP, OP_CALL, OP_ALU, literal bit 15).
//  - Sub-module fetch_buffer: BUF_DEPTH-entry FIFO of {pc, word}, push/pop/
//    flush, count output; flush beats push in the same cycle.
// TESTING
//  - Reset then fetch_enable=1, ready=1, RAM words 0..4: instr_pc 0,1,2,3,4 on
//    consecutive cycles, first instr_valid 2 cycles after enable.
//  - ready low 5 cycles mid-stream: instr/instr_pc held, no word lost or
//    duplicated, fetch_address stops advancing, resumes in order.
//  - redirect_valid to 0x100 while buffer holds 2 words: both dropped, next
//    instr_pc=0x100 two cycles later, then 0x101.
//  - PC wrap: redirect to 0x1FFF: instr_pc 0x1FFF then 0x0000.
//  - reset_n low mid-stream with in-flight fetch: instr_valid=0 next cycle,
//    restart from RESET_ADDR; fetch_enable=0: drains buffer, no new issues.
//  - With IFETCH_JUMP_PREDECODE_EN, word 0x0040 at addr 2: stream 0,1,2,0x40;
//    without it: 0,1,2,3 until redirect.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the j2 instruction fetch stage: default widths,
// reset address, opcode field constants and the FSM state type.
// Optional build macro: IFETCH_JUMP_PREDECODE_EN (see instruction_fetch.sv).
package instruction_fetch_pkg;

  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_BUF_DEPTH  = 2;

  // j2 opcode field lives in bits [15:13]; bit 15 set marks a literal
  localparam int         OP_MSB  = 15;
  localparam int         OP_LSB  = 13;
  localparam int         LIT_BIT = 15;
  localparam logic [2:0] OP_JUMP  = 3'b000;
  localparam logic [2:0] OP_CJUMP = 3'b001;
  localparam logic [2:0] OP_CALL  = 3'b010;
  localparam logic [2:0] OP_ALU   = 3'b011;

  // Jump target field width of an unconditional jump word
  localparam int JUMP_TARGET_BITS = 13;

  typedef enum logic {
    HALTED  = 1'b0,
    RUNNING = 1'b1
  } fetch_state_t;

  // Unconditional jump: opcode 000 and not a literal
  function automatic logic is_jump(input logic [15:0] word);
    return (word[OP_MSB:OP_LSB] == OP_JUMP) && !word[LIT_BIT];
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch stage bus: run/redirect control from the core, the instruction RAM
// read port and the valid/ready handshake towards decode.
// master = fetch stage, slave = its environment (core, RAM, decode).
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16
);
  logic                  fetch_enable;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_address;
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;

  modport master (
    input  fetch_enable, redirect_valid, redirect_address, fetch_data, instr_ready,
    output fetch_address, instr_valid, instr, instr_pc
  );

  modport slave (
    output fetch_enable, redirect_valid, redirect_address, fetch_data, instr_ready,
    input  fetch_address, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/instruction_fetch_buffer.sv
// Small FIFO of fetched {pc, word} pairs sitting between the instruction RAM
// and decode. Head entry is read straight from storage registers. A flush
// empties the FIFO and wins over a push in the same cycle.
module instruction_fetch_buffer #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 2,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic [DATA_WIDTH-1:0] push_word,
  input  logic                  pop,
  input  logic                  flush,
  output logic                  head_valid,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic [DATA_WIDTH-1:0] head_word,
  output logic [CNT_W-1:0]      count
);
  localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] word_mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_valid = (count != '0);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_word  = word_mem[rd_ptr];
  assign do_pop     = pop && head_valid;

  // Storage, pointers and occupancy count
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        word_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]   <= push_pc;
        word_mem[wr_ptr] <= push_word;
        wr_ptr           <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The issue credit rule in the fetch stage must keep pushes off a full FIFO
  push_on_full: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !flush && (count == FULL)));

endmodule

// File: rtl/instruction_fetch.sv
// j2 fetch stage: owns the PC, drives the instruction RAM read address,
// absorbs the RAM's one-cycle read latency and hands words to decode through
// a small buffer so decode stalls never drop instructions.
// Optional build macro: IFETCH_JUMP_PREDECODE_EN -- when defined, an
// unconditional jump word returning from RAM retargets the PC directly and
// the sequential fetch of that cycle is not issued.
//
// state   | meaning
// HALTED  | no new fetches issued; buffered words still drain to decode
// RUNNING | a fetch is issued every cycle the buffer has credit
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter int                    BUF_DEPTH  = DEF_BUF_DEPTH
) (
  input logic                 clock,
  input logic                 reset_n,
  instruction_fetch_if.master bus
);
  localparam int               CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int               OCC_W     = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(BUF_DEPTH);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic [CNT_W-1:0]      count;
  logic [OCC_W-1:0]      occupancy;
  logic                  pop;
  logic                  push;
  logic                  credit;
  logic                  issue;
  logic                  jump_hit;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic                  head_valid;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [DATA_WIDTH-1:0] head_word;

  // A redirect is presented to the RAM in the same cycle it arrives
  assign fetch_address     = bus.redirect_valid ? bus.redirect_address : pc;
  assign bus.fetch_address = fetch_address;

  assign pop  = head_valid && bus.instr_ready;
  // A redirect discards the word returning for the previous fetch
  assign push = inflight && !bus.redirect_valid;

  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_word;
  assign bus.instr_pc    = head_pc;

  // Jump predecode on the word returning from RAM (inert unless enabled)
  always_comb begin
    jump_hit    = 1'b0;
    jump_target = pc;
`ifdef IFETCH_JUMP_PREDECODE_EN
    jump_hit    = push && is_jump(bus.fetch_data[15:0]);
    jump_target = ADDR_WIDTH'(bus.fetch_data[JUMP_TARGET_BITS-1:0]);
`endif
  end

  // Issue decision: buffered plus in-flight words may never exceed the depth
  always_comb begin
    occupancy = {1'b0, count} + OCC_W'(inflight);
    credit    = (occupancy < DEPTH_OCC) || ((occupancy == DEPTH_OCC) && pop);
    issue     = (state == RUNNING) && (bus.redirect_valid || (credit && !jump_hit));
  end

  // Run/halt FSM, program counter and in-flight fetch tracking
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= HALTED;
      pc          <= RESET_ADDR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      case (state)
        HALTED:  if (bus.fetch_enable)  state <= RUNNING;
        RUNNING: if (!bus.fetch_enable) state <= HALTED;
        default: state <= HALTED;
      endcase
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_address;
        pc          <= fetch_address + ADDR_WIDTH'(1);
      end else if (bus.redirect_valid) begin
        pc <= bus.redirect_address;
      end else if (jump_hit) begin
        pc <= jump_target;
      end
    end
  end

  instruction_fetch_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buffer (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (push),
    .push_pc    (inflight_pc),
    .push_word  (bus.fetch_data),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_word  (head_word),
    .count      (count)
  );

endmodule
